// File: rtl/peak_frame_source_pkg.sv
// Shared widths, FSM state encoding and beat payload for the peak frame source.
package peak_frame_source_pkg;

    localparam int unsigned VALUE_WIDTH = 32;
    localparam int unsigned INDEX_WIDTH = 11;
    localparam int unsigned FRAME_LEN   = 1024;
    localparam int unsigned TIMEOUT     = 4096;

    localparam int unsigned ADDR_WIDTH  = $clog2(FRAME_LEN);
    localparam int unsigned GAP_WIDTH   = 4;
    // Wait counter only has to reach TIMEOUT-1.
    localparam int unsigned WAIT_WIDTH  = $clog2(TIMEOUT);

    // FSM state encoding, exported so benches can probe the state register.
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t PRIME    = 2'd1;
    localparam state_t STREAM   = 2'd2;
    localparam state_t WAIT_RES = 2'd3;

    // Control half of one output beat; data comes straight from the RAM read register.
    typedef struct packed {
        logic                   valid;
        logic                   last;
        logic [INDEX_WIDTH-1:0] index;
    } beat_ctl_t;

    // Requested lengths above the RAM depth are replayed as a full RAM.
    function automatic logic [INDEX_WIDTH-1:0] clamp_len(input logic [INDEX_WIDTH-1:0] len);
        if (len > INDEX_WIDTH'(FRAME_LEN)) begin
            return INDEX_WIDTH'(FRAME_LEN);
        end
        return len;
    endfunction

endpackage

// File: rtl/peak_frame_source_frame_ram.sv
// Frame sample store: one write port, one registered read port (1-cycle latency).
module peak_frame_source_frame_ram
    import peak_frame_source_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_i,
    input  logic [VALUE_WIDTH-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [ADDR_WIDTH-1:0]  raddr_i,
    output logic [VALUE_WIDTH-1:0] rdata_o
);

    logic [VALUE_WIDTH-1:0] mem_q [FRAME_LEN];
    logic [VALUE_WIDTH-1:0] rdata_q;

    // Sample storage; deliberately not reset so a frame survives a block reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; holds its value when no read is issued (gap cycles).
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/peak_frame_source.sv
// Replays one stored frame into the peak detector with a programmable gap
// pattern, then waits for the detector's result or times out.
module peak_frame_source
    import peak_frame_source_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_addr,
    input  logic [VALUE_WIDTH-1:0] wr_data,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] frame_len,
    input  logic [GAP_WIDTH-1:0]   gap_period,
    input  logic                   last_in,
    output logic                   valid_o,
    output logic [VALUE_WIDTH-1:0] data_o,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic                   last_o,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   wr_reject
);

    state_t                 state_q, state_d;
    beat_ctl_t              beat_q, beat_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] len_q, len_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   wr_reject_q, wr_reject_d;

    logic                   ram_we_c;
    logic                   ram_re_c;
    logic [ADDR_WIDTH-1:0]  ram_raddr_c;
    logic [VALUE_WIDTH-1:0] ram_rdata;

    // Writes land only while idle, so a write alongside start is visible to that frame.
    assign ram_we_c = wr_en && (state_q == IDLE) && (wr_addr < INDEX_WIDTH'(FRAME_LEN));

    peak_frame_source_frame_ram u_frame_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we_c),
        .waddr_i (wr_addr[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re_c),
        .raddr_i (ram_raddr_c),
        .rdata_o (ram_rdata)
    );

    // Next-state and next-output logic; decisions here shape the following cycle's beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        beat_d.valid = 1'b0;
        beat_d.last  = 1'b0;
        idx_d       = idx_q;
        len_d       = len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        wr_reject_d = wr_en && (state_q != IDLE);
        ram_re_c    = 1'b0;
        ram_raddr_c = idx_q[ADDR_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    if (frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d     = clamp_len(frame_len);
                        gap_d     = gap_period;
                        idx_d     = '0;
                        gap_cnt_d = '0;
                        state_d   = PRIME;
                    end
                end
            end

            // PRIME issues the read for beat 0; STREAM issues each following beat or gap.
            PRIME, STREAM: begin
                if (beat_q.last) begin
                    wait_d  = '0;
                    state_d = WAIT_RES;
                end else if ((gap_q != '0) && (gap_cnt_q == gap_q)) begin
                    gap_cnt_d = '0;
                    state_d   = STREAM;
                end else begin
                    ram_re_c     = 1'b1;
                    beat_d.valid = 1'b1;
                    beat_d.index = idx_q;
                    beat_d.last  = (idx_q == (len_q - INDEX_WIDTH'(1)));
                    idx_d        = idx_q + INDEX_WIDTH'(1);
                    gap_cnt_d    = gap_cnt_q + GAP_WIDTH'(1);
                    state_d      = STREAM;
                end
            end

            WAIT_RES: begin
                if (last_in) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_WIDTH'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_WIDTH'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_q      <= wait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign valid_o   = beat_q.valid;
    assign last_o    = beat_q.last;
    assign index_o   = beat_q.index;
    assign data_o    = ram_rdata;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign wr_reject = wr_reject_q;

endmodule
